// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared encodings for the MEM-stage data memory access controller:
//   - access size codes (req_size)
//   - load data extender op codes (ext_op)
//   - controller FSM state encoding
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

  // Access size codes; code 3 is illegal and handled as a word access.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Downstream load data extender operations.
  typedef enum logic [2:0] {
    EXT_W  = 3'd0,
    EXT_BU = 3'd1,
    EXT_B  = 3'd2,
    EXT_HU = 3'd3,
    EXT_H  = 3'd4
  } ext_op_t;

  // Controller FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mem_access_ctrl_pkg

// File: rtl/mem_lane_gen.sv
// -----------------------------------------------------------------------------
// mem_lane_gen
// Purely combinational byte-lane logic for one load/store request.
// Ports:
//   size       in  2   access size code (SZ_*), 3 treated as word
//   offset     in  2   byte offset within the word (addr[1:0])
//   is_signed  in  1   sign-extending load
//   we         in  1   1 = store, 0 = load
//   wdata      in  32  right-aligned store data
//   be         out 4   byte enables (same for loads and stores)
//   wdata_rep  out 32  store data replicated across the selected lanes
//   ext_op     out 3   extender op for a load, EXT_W for a store
//   misaligned out 1   half at odd address or word not on a word boundary
// -----------------------------------------------------------------------------
module mem_lane_gen
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        is_signed,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output ext_op_t     ext_op,
  output logic        misaligned
);

  // NOTE: every output gets a default before the case so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    be         = 4'b1111;
    wdata_rep  = wdata;
    ext_op     = EXT_W;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << offset;
        wdata_rep = {4{wdata[7:0]}};
        ext_op    = is_signed ? EXT_B : EXT_BU;
      end
      SZ_HALF: begin
        be         = offset[1] ? 4'b1100 : 4'b0011;
        wdata_rep  = {2{wdata[15:0]}};
        ext_op     = is_signed ? EXT_H : EXT_HU;
        misaligned = offset[0];
      end
      default: begin
        // SZ_WORD and the illegal code 3 both behave as a word access.
        misaligned = (offset != 2'b00);
      end
    endcase
    // The extender is irrelevant for stores; keep its op neutral.
    if (we) begin
      ext_op = EXT_W;
    end
  end

endmodule : mem_lane_gen

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Sequences MEM-stage loads/stores onto a variable-latency data memory port,
// stalls the pipeline while an access is in flight, latches the raw read word
// and the extender configuration, and filters misaligned accesses.
//
// Optional feature macro: MEM_TIMEOUT_EN
//   When defined, a BUSY access that sees no mem_ready for TIMEOUT_CYCLES
//   cycles is aborted; the response carries bus_err=1 and rdata_raw=0.
//
// Ports:
//   clk, reset             clock and synchronous active-high reset
//   req_valid/we/size/signed/addr/wdata   request from the MEM stage
//   stall                  freeze IF..MEM (combinational accept in IDLE)
//   resp_valid             one-cycle completion pulse
//   rdata_raw              latched read word for the extender
//   ext_op, ext_offset     extender op and byte offset (latched on loads)
//   adel, ades             load / store address error
//   bus_err                timeout abort flag (MEM_TIMEOUT_EN only)
//   mem_req/we/be/addr/wdata   memory request, held until mem_ready
//   mem_ready, mem_rdata   memory completion and read data
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       rdata_raw,
  output logic [2:0]        ext_op,
  output logic [1:0]        ext_offset,
  output logic              adel,
  output logic              ades,
`ifdef MEM_TIMEOUT_EN
  output logic              bus_err,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t      state;
  logic        is_load;   // the in-flight access is a load

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  ext_op_t     lane_ext_op;
  logic        lane_misaligned;
  logic        is_idle;
  logic        accept;

  mem_lane_gen u_lane (
    .size       (req_size),
    .offset     (req_addr[1:0]),
    .is_signed  (req_signed),
    .we         (req_we),
    .wdata      (req_wdata),
    .be         (lane_be),
    .wdata_rep  (lane_wdata),
    .ext_op     (lane_ext_op),
    .misaligned (lane_misaligned)
  );

  // Requests are only examined in IDLE; in DONE the pipeline is advancing
  // past the completed instruction, so its still-visible req_valid is ignored.
  assign is_idle = (state == IDLE);
  assign accept  = is_idle & req_valid & ~lane_misaligned;
  assign adel    = is_idle & req_valid & ~req_we & lane_misaligned;
  assign ades    = is_idle & req_valid &  req_we & lane_misaligned;

  // Stall must rise in the accept cycle itself, before the state register
  // has moved, so the instruction in MEM is held for the whole access.
  assign stall      = accept | (state == BUSY);
  assign mem_req    = (state == BUSY);
  assign resp_valid = (state == DONE);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] busy_cnt;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  // NOTE: reset clears every register, including the data latches, so the
  // extender and the memory port never see stale contents after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      is_load    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0;
      rdata_raw  <= 32'h0;
      ext_op     <= EXT_W;
      ext_offset <= 2'b00;
`ifdef MEM_TIMEOUT_EN
      busy_cnt   <= '0;
      bus_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef MEM_TIMEOUT_EN
          busy_cnt <= '0;
          bus_err  <= 1'b0;
`endif
          if (accept) begin
            state     <= BUSY;
            is_load   <= ~req_we;
            mem_we    <= req_we;
            mem_be    <= lane_be;
            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= lane_wdata;
            // The extender configuration belongs to the most recent load;
            // stores leave it untouched.
            if (!req_we) begin
              ext_op     <= lane_ext_op;
              ext_offset <= req_addr[1:0];
            end
          end
        end

        BUSY: begin
          if (mem_ready) begin
            state <= DONE;
            if (is_load) begin
              rdata_raw <= mem_rdata;
            end
          end
`ifdef MEM_TIMEOUT_EN
          // busy_cnt holds the number of BUSY cycles already elapsed, so
          // this is the TIMEOUT_CYCLES-th cycle without a response.
          else if (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= DONE;
            bus_err   <= 1'b1;
            rdata_raw <= 32'h0;
          end else begin
            busy_cnt <= busy_cnt + 1'b1;
          end
`endif
        end

        DONE: begin
          state <= IDLE;
`ifdef MEM_TIMEOUT_EN
          bus_err <= 1'b0;
`endif
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : mem_access_ctrl
